doppler_gate_sampler: RTL

- Upstream producer for the PRF data buffer stage.
- On each transmit event it waits a programmable range-gate delay, then captures ADC samples and packs LANES samples into one word per output beat.
- Each packed word is announced by advancing a 2-bit samplingTrigger count. A one-cycle prfFinish pulse closes each PRF window, so the downstream buffer can count PRFs and latch words.

---
 rtl/doppler_pkg.sv | 19 +
 rtl/doppler_gate_sampler_sample_packer.sv | 46 ++++
 rtl/doppler_gate_sampler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/doppler_pkg.sv
// Shared definitions for the Doppler range-gate sampler.
// Holds the default sample geometry, the packed word width and the
// sequencer state encoding used by doppler_gate_sampler.
package doppler_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_LANES    = 4;
    localparam int DEF_DELAY_W  = 16;
    localparam int DEF_LEN_W    = 8;
    localparam int DEF_WORD_W   = DEF_SAMPLE_W * DEF_LANES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        ACQUIRE = 2'd2,
        FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/doppler_gate_sampler_sample_packer.sv
// sample_packer: collects LANES samples into one packed word.
// Lane k occupies bits [k*SAMPLE_W +: SAMPLE_W]; lane 0 is the first sample.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   sample      - sample to insert at the current lane index
//   valid       - insert strobe (already qualified by the caller)
//   word        - packed word including the sample presented this cycle
//   word_done   - high when this cycle's sample completes the word
module sample_packer
    import doppler_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int LANES    = DEF_LANES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SAMPLE_W-1:0]          sample,
    input  logic                         valid,
    output logic [SAMPLE_W*LANES-1:0]    word,
    output logic                         word_done
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [SAMPLE_W*LANES-1:0] lanes_q;
    logic [IDX_W-1:0]          idx_q;

    // The word is presented with the current sample already inserted so
    // the caller can register the complete word on the same edge.
    always_comb begin
        word = lanes_q;
        word[idx_q*SAMPLE_W +: SAMPLE_W] = sample;
        word_done = valid && (idx_q == IDX_W'(LANES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (valid) begin
            lanes_q <= word;
            idx_q   <= word_done ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/doppler_gate_sampler.sv
// doppler_gate_sampler: range-gated ADC capture for one PRF window.
// After prfStart the sequencer discards gateDelay valid samples, then packs
// gateLen words of LANES samples each, announcing every new word by stepping
// the free-running samplingTrigger count, and closes with a prfFinish pulse.
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   adcData/adcValid - ADC sample and its strobe
//   prfStart         - transmit pulse opening a window
//   gateDelay        - valid samples to discard (latched at prfStart)
//   gateLen          - words to capture (latched at prfStart)
//   dataOut          - last completed packed word
//   samplingTrigger  - modulo-4 word counter, +1 per new dataOut
//   prfFinish        - one-cycle end-of-window pulse (the FINISH state)
//   busy             - high in DELAY and ACQUIRE
//   overrun          - sticky: prfStart seen outside IDLE
//   dbg_state        - current sequencer state
//
// Handshake: adcValid is a strobe without backpressure; a sample is taken on
// every posedge where adcValid is high. dataOut and samplingTrigger change
// together, one clk after the adcValid that completes a word.
module doppler_gate_sampler
    import doppler_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int LANES    = DEF_LANES,
    parameter int DELAY_W  = DEF_DELAY_W,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SAMPLE_W-1:0]       adcData,
    input  logic                      adcValid,
    input  logic                      prfStart,
    input  logic [DELAY_W-1:0]        gateDelay,
    input  logic [LEN_W-1:0]          gateLen,
    output logic [SAMPLE_W*LANES-1:0] dataOut,
    output logic [1:0]                samplingTrigger,
    output logic                      prfFinish,
    output logic                      busy,
    output logic                      overrun,
    output state_t                    dbg_state
);

    state_t               state_q, state_d;
    logic [DELAY_W-1:0]   delay_q;
    logic [LEN_W-1:0]     len_q;
    logic [SAMPLE_W*LANES-1:0] word;
    logic                 word_done;
    logic                 pack_valid;

    assign pack_valid = adcValid && (state_q == ACQUIRE);

    sample_packer #(
        .SAMPLE_W (SAMPLE_W),
        .LANES    (LANES)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .sample    (adcData),
        .valid     (pack_valid),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (prfStart) begin
                    if (gateDelay != '0)   state_d = DELAY;
                    else if (gateLen != '0) state_d = ACQUIRE;
                    else                    state_d = FINISH;
                end
            end
            DELAY: begin
                // The sample that empties the delay count is discarded.
                if (adcValid && (delay_q == DELAY_W'(1)))
                    state_d = (len_q != '0) ? ACQUIRE : FINISH;
            end
            ACQUIRE: begin
                if (word_done && (len_q == LEN_W'(1)))
                    state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            delay_q         <= '0;
            len_q           <= '0;
            dataOut         <= '0;
            samplingTrigger <= '0;
            overrun         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && prfStart) begin
                delay_q <= gateDelay;
                len_q   <= gateLen;
            end
            if (state_q == DELAY && adcValid)
                delay_q <= delay_q - DELAY_W'(1);
            if (word_done) begin
                dataOut         <= word;
                samplingTrigger <= samplingTrigger + 2'd1;
                len_q           <= len_q - LEN_W'(1);
            end
            // A new transmit before the window closed cannot be honoured.
            if (prfStart && state_q != IDLE)
                overrun <= 1'b1;
        end
    end

    assign prfFinish = (state_q == FINISH);
    assign busy      = (state_q == DELAY) || (state_q == ACQUIRE);
    assign dbg_state = state_q;

endmodule
